// File: rtl/phy_config_sequencer.sv
// PHY configuration sequencer: latches link settings on START, writes the
// control, test-mode and two clock-skew registers over a req/ack register
// port, then periodically reads the status register to report link state.
module phy_config_sequencer #(
  parameter int                ADDR_W      = 9,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] CTRL_ADDR   = 9'h000,
  parameter logic [ADDR_W-1:0] TEST_ADDR   = 9'h009,
  parameter logic [ADDR_W-1:0] SKEW1_ADDR  = 9'h104,
  parameter logic [ADDR_W-1:0] SKEW2_ADDR  = 9'h105,
  parameter logic [ADDR_W-1:0] STATUS_ADDR = 9'h001,
  parameter int                LINK_BIT    = 2,
  parameter int                POLL_CYCLES = 1000000,
  parameter int                ACK_TIMEOUT = 1024,
  parameter bit                AUTO_START  = 1'b1,
  parameter bit                POLL_EN     = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [1:0]        SPEED,
  input  logic              DUPLEX,
  input  logic [1:0]        TEST_MODE,
  input  logic              POWER_DOWN,
  input  logic [15:0]       CLK_SKEW1,
  input  logic [15:0]       CLK_SKEW2,
  output logic              REG_REQ,
  output logic              REG_WE,
  output logic [ADDR_W-1:0] REG_ADDR,
  output logic [DATA_W-1:0] REG_WDATA,
  input  logic              REG_ACK,
  input  logic [DATA_W-1:0] REG_RDATA,
  output logic              BUSY,
  output logic              CFG_DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] STATUS,
  output logic              STATUS_VALID,
  output logic              LINK_UP
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WR_CTRL, WR_TEST, WR_SKEW1, WR_SKEW2, FINISH, POLL_WAIT, RD_STATUS
  } state_t;

  state_t            state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, status_q, status_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              sv_q, sv_d, link_q, link_d, auto_q, auto_d;
  logic [PW-1:0]     poll_cnt_q, poll_cnt_d;
  logic [TW-1:0]     to_cnt_q, to_cnt_d;
  logic [1:0]        tm_q, tm_d;
  logic [15:0]       sk1_q, sk1_d, sk2_q, sk2_d;
  logic              start_ok;

  function automatic logic [DATA_W-1:0] ctrl_word(input logic [1:0] spd,
                                                  input logic dup, input logic pd);
    logic [DATA_W-1:0] w;
    w     = '0;
    w[13] = spd[0];
    w[6]  = spd[1];
    w[8]  = dup;
    w[11] = pd;
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] test_word(input logic [1:0] tm);
    logic [DATA_W-1:0] w;
    w        = '0;
    w[14:13] = tm;
    return w;
  endfunction

  // Next-state logic: launch, access handshake with timeout, polling timer
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    status_d   = status_q;
    sv_d       = 1'b0;
    link_d     = link_q;
    poll_cnt_d = poll_cnt_q;
    to_cnt_d   = to_cnt_q;
    auto_d     = 1'b0;
    tm_d       = tm_q;
    sk1_d      = sk1_q;
    sk2_d      = sk2_q;
    start_ok   = (START || auto_q) && (state_q == IDLE || state_q == POLL_WAIT);

    if (start_ok) begin
      // START wins over a simultaneous poll expiry
      tm_d     = TEST_MODE;
      sk1_d    = CLK_SKEW1;
      sk2_d    = CLK_SKEW2;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      err_d    = 1'b0;
      req_d    = 1'b0;
      we_d     = 1'b1;
      addr_d   = CTRL_ADDR;
      wdata_d  = ctrl_word(SPEED, DUPLEX, POWER_DOWN);
      state_d  = WR_CTRL;
    end else begin
      case (state_q)
        POLL_WAIT: begin
          if (poll_cnt_q == POLL_LAST) begin
            state_d    = RD_STATUS;
            we_d       = 1'b0;
            addr_d     = STATUS_ADDR;
            wdata_d    = '0;
            poll_cnt_d = '0;
          end else begin
            poll_cnt_d = poll_cnt_q + PW'(1);
          end
        end
        WR_CTRL, WR_TEST, WR_SKEW1, WR_SKEW2, RD_STATUS: begin
          if (!req_q) begin
            // first cycle in the state: raise the request with fields already stable
            req_d    = 1'b1;
            to_cnt_d = '0;
          end else if (REG_ACK) begin
            req_d = 1'b0;
            case (state_q)
              WR_CTRL: begin
                state_d = WR_TEST;
                addr_d  = TEST_ADDR;
                wdata_d = test_word(tm_q);
              end
              WR_TEST: begin
                state_d = WR_SKEW1;
                addr_d  = SKEW1_ADDR;
                wdata_d = DATA_W'(sk1_q);
              end
              WR_SKEW1: begin
                state_d = WR_SKEW2;
                addr_d  = SKEW2_ADDR;
                wdata_d = DATA_W'(sk2_q);
              end
              WR_SKEW2: state_d = FINISH;
              default: begin
                status_d   = REG_RDATA;
                link_d     = REG_RDATA[LINK_BIT];
                sv_d       = 1'b1;
                poll_cnt_d = '0;
                state_d    = POLL_WAIT;
              end
            endcase
          end else if (to_cnt_q == TO_LAST) begin
            req_d   = 1'b0;
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
        end
        FINISH: begin
          done_d     = 1'b1;
          busy_d     = 1'b0;
          poll_cnt_d = '0;
          state_d    = POLL_EN ? POLL_WAIT : IDLE;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; settings shadows carry no reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      status_q   <= '0;
      sv_q       <= 1'b0;
      link_q     <= 1'b0;
      poll_cnt_q <= '0;
      to_cnt_q   <= '0;
      auto_q     <= AUTO_START;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      status_q   <= status_d;
      sv_q       <= sv_d;
      link_q     <= link_d;
      poll_cnt_q <= poll_cnt_d;
      to_cnt_q   <= to_cnt_d;
      auto_q     <= auto_d;
    end
    tm_q  <= tm_d;
    sk1_q <= sk1_d;
    sk2_q <= sk2_d;
  end

  assign REG_REQ      = req_q;
  assign REG_WE       = we_q;
  assign REG_ADDR     = addr_q;
  assign REG_WDATA    = wdata_q;
  assign BUSY         = busy_q;
  assign CFG_DONE     = done_q;
  assign ERR          = err_q;
  assign STATUS       = status_q;
  assign STATUS_VALID = sv_q;
  assign LINK_UP      = link_q;

endmodule

// File: tb/tb_phy_config_sequencer.sv
// Bench for phy_config_sequencer: write accesses are scored against a queue
// of expected {we, addr, data} records; timing and corner cases are checked
// with hand-written sequences and a table of configuration vectors.
module tb_phy_config_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, START2;
  logic [1:0]  SPEED, TEST_MODE;
  logic        DUPLEX, POWER_DOWN;
  logic [15:0] CLK_SKEW1, CLK_SKEW2;
  logic        REG_ACK, REG_ACK2;
  logic [15:0] REG_RDATA;

  logic        REG_REQ, REG_WE, BUSY, CFG_DONE, ERR, STATUS_VALID, LINK_UP;
  logic [8:0]  REG_ADDR;
  logic [15:0] REG_WDATA, STATUS;

  logic        REG_REQ2, REG_WE2, BUSY2, CFG_DONE2, ERR2, STATUS_VALID2, LINK_UP2;
  logic [8:0]  REG_ADDR2;
  logic [15:0] REG_WDATA2, STATUS2;

  always #5 CLK = ~CLK;

  phy_config_sequencer #(.POLL_CYCLES(8), .ACK_TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .SPEED(SPEED), .DUPLEX(DUPLEX),
    .TEST_MODE(TEST_MODE), .POWER_DOWN(POWER_DOWN), .CLK_SKEW1(CLK_SKEW1),
    .CLK_SKEW2(CLK_SKEW2), .REG_REQ(REG_REQ), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR),
    .REG_WDATA(REG_WDATA), .REG_ACK(REG_ACK), .REG_RDATA(REG_RDATA), .BUSY(BUSY),
    .CFG_DONE(CFG_DONE), .ERR(ERR), .STATUS(STATUS), .STATUS_VALID(STATUS_VALID),
    .LINK_UP(LINK_UP));

  phy_config_sequencer #(.POLL_CYCLES(8), .ACK_TIMEOUT(16), .AUTO_START(1'b0),
                         .POLL_EN(1'b0)) dut2 (
    .CLK(CLK), .RST(RST), .START(START2), .SPEED(SPEED), .DUPLEX(DUPLEX),
    .TEST_MODE(TEST_MODE), .POWER_DOWN(POWER_DOWN), .CLK_SKEW1(CLK_SKEW1),
    .CLK_SKEW2(CLK_SKEW2), .REG_REQ(REG_REQ2), .REG_WE(REG_WE2), .REG_ADDR(REG_ADDR2),
    .REG_WDATA(REG_WDATA2), .REG_ACK(REG_ACK2), .REG_RDATA(REG_RDATA), .BUSY(BUSY2),
    .CFG_DONE(CFG_DONE2), .ERR(ERR2), .STATUS(STATUS2), .STATUS_VALID(STATUS_VALID2),
    .LINK_UP(LINK_UP2));

  typedef struct packed {
    logic        we;
    logic [8:0]  addr;
    logic [15:0] data;
  } acc_t;

  typedef struct {
    logic [1:0]  spd;
    logic        dup;
    logic [1:0]  tm;
    logic        pd;
    logic [15:0] s1, s2, ctrl, test;
    int          dly;
    int          lat;
  } vec_t;

  acc_t exp_q[$];
  int   cmp_cnt = 0, err_cnt = 0;
  int   ack_delay = 0, req_run = 0, last_run = 0, req_starts = 0, reads = 0;
  int   req2_starts = 0, sv2_cnt = 0;
  logic blk_en = 1'b0;
  logic [8:0] blk_addr = 9'h000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_cfg(input logic [15:0] c, input logic [15:0] t,
                          input logic [15:0] s1, input logic [15:0] s2);
    exp_q.push_back('{1'b1, 9'h000, c});
    exp_q.push_back('{1'b1, 9'h009, t});
    exp_q.push_back('{1'b1, 9'h104, s1});
    exp_q.push_back('{1'b1, 9'h105, s2});
  endtask

  task automatic set_in(input logic [1:0] s, input logic d, input logic [1:0] t,
                        input logic p, input logic [15:0] k1, input logic [15:0] k2);
    SPEED = s; DUPLEX = d; TEST_MODE = t; POWER_DOWN = p; CLK_SKEW1 = k1; CLK_SKEW2 = k2;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (!CFG_DONE && n < max);
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (!STATUS_VALID && n < max);
  endtask

  task automatic check_zero(input string name);
    check({name, "_flags"}, 32'({REG_REQ, REG_WE, BUSY, CFG_DONE, ERR, STATUS_VALID, LINK_UP}), 32'h0);
    check({name, "_addr"}, 32'(REG_ADDR), 32'h0);
    check({name, "_wdata"}, 32'(REG_WDATA), 32'h0);
    check({name, "_status"}, 32'(STATUS), 32'h0);
  endtask

  // Register-port responder and access monitor for the main DUT
  initial begin
    acc_t cur, e;
    logic ack_prev, req_prev;
    cur = '0; ack_prev = 1'b0; req_prev = 1'b0;
    REG_ACK = 1'b0;
    forever begin
      @(negedge CLK);
      if (ack_prev) check("req_gap", 32'(REG_REQ), 32'h0);
      if (REG_REQ) begin
        if (!req_prev) begin
          req_starts++;
          req_run = 0;
          cur = '{REG_WE, REG_ADDR, REG_WDATA};
        end else begin
          check("req_stable", 32'({REG_WE, REG_ADDR, REG_WDATA}), 32'(cur));
        end
        req_run++;
        if (req_run > ack_delay && !(blk_en && REG_ADDR == blk_addr)) begin
          REG_ACK = 1'b1;
          if (cur.we) begin
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
            if (exp_q.size() != 0) begin
              e = exp_q.pop_front();
              check("wr_access", 32'(cur), 32'(e));
            end
          end else begin
            reads++;
            check("rd_access", 32'(cur), 32'({1'b0, 9'h001, 16'h0000}));
          end
        end else begin
          REG_ACK = 1'b0;
        end
      end else begin
        if (req_prev && !ack_prev) last_run = req_run;
        REG_ACK = 1'b0;
      end
      ack_prev = REG_ACK;
      req_prev = REG_REQ;
    end
  end

  // Zero-wait responder for the AUTO_START=0 / POLL_EN=0 instance
  initial begin
    logic r2_prev;
    r2_prev = 1'b0;
    REG_ACK2 = 1'b0;
    forever begin
      @(negedge CLK);
      if (REG_REQ2 && !r2_prev) req2_starts++;
      if (STATUS_VALID2) sv2_cnt++;
      REG_ACK2 = REG_REQ2;
      r2_prev = REG_REQ2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[3];
    int n, snap;
    tbl[0] = '{2'b00, 1'b0, 2'b11, 1'b0, 16'h0001, 16'h8000, 16'h0000, 16'h6000, 0, 9};
    tbl[1] = '{2'b01, 1'b1, 2'b01, 1'b0, 16'h0F0F, 16'hF0F0, 16'h2100, 16'h2000, 0, 9};
    tbl[2] = '{2'b10, 1'b0, 2'b10, 1'b1, 16'h7FFF, 16'h0000, 16'h0840, 16'h4000, 5, 29};

    RST = 1'b1; START = 1'b0; START2 = 1'b0; REG_RDATA = 16'h0004;
    set_in(2'b10, 1'b1, 2'b00, 1'b0, 16'h00A5, 16'h5A00);
    repeat (3) tick();
    check_zero("rst");

    // Auto-start after reset release, zero-wait ACK
    push_cfg(16'h0140, 16'h0000, 16'h00A5, 16'h5A00);
    RST = 1'b0;
    repeat (9) tick();
    check("t1_pre_done", 32'({CFG_DONE, BUSY}), 32'h1);
    tick();
    check("t1_done", 32'({CFG_DONE, BUSY}), 32'h2);
    check("t1_sb_drained", 32'(exp_q.size()), 32'h0);
    check("opt_noauto_reqs", 32'(req2_starts), 32'h0);
    check("opt_noauto_busy", 32'(BUSY2), 32'h0);

    // Polling: first read completes 10 cycles after CFG_DONE, then every 10
    wait_valid(30, n);
    check("t2_first_poll", 32'(n), 32'd10);
    check("t2_status", 32'(STATUS), 32'h0004);
    check("t2_link_up", 32'(LINK_UP), 32'h1);
    tick();
    check("t2_valid_pulse", 32'(STATUS_VALID), 32'h0);
    wait_valid(30, n);
    check("t2_poll_period", 32'(n), 32'd9);
    check("t2_reads", 32'(reads), 32'd2);

    // Reconfiguration from POLL_WAIT; later input changes and a START in WR_SKEW1 are ignored
    set_in(2'b01, 1'b0, 2'b00, 1'b1, 16'h1234, 16'hBEEF);
    push_cfg(16'h2800, 16'h0000, 16'h1234, 16'hBEEF);
    START = 1'b1; tick(); START = 1'b0;
    set_in(2'b10, 1'b1, 2'b11, 1'b0, 16'hFFFF, 16'h0000);
    repeat (4) tick();
    START = 1'b1; tick(); START = 1'b0;
    repeat (3) tick();
    check("t4_busy", 32'({CFG_DONE, BUSY}), 32'h1);
    check("t4_status_hold", 32'(STATUS), 32'h0004);
    check("t4_link_hold", 32'(LINK_UP), 32'h1);
    tick();
    check("t4_done", 32'({CFG_DONE, BUSY}), 32'h2);
    REG_RDATA = 16'h0000;
    wait_valid(30, n);
    check("t2_link_down", 32'({LINK_UP, STATUS}), 32'h0);

    // Table of configurations, the last one with 5 wait states per access
    for (int i = 0; i < 3; i++) begin
      set_in(tbl[i].spd, tbl[i].dup, tbl[i].tm, tbl[i].pd, tbl[i].s1, tbl[i].s2);
      push_cfg(tbl[i].ctrl, tbl[i].test, tbl[i].s1, tbl[i].s2);
      ack_delay = tbl[i].dly;
      START = 1'b1; tick(); START = 1'b0;
      check("tbl_launch", 32'({BUSY, ERR, CFG_DONE}), 32'h4);
      wait_done(60, n);
      check("tbl_latency", 32'(n), 32'(tbl[i].lat));
      check("tbl_sb_drained", 32'(exp_q.size()), 32'h0);
    end
    ack_delay = 0;

    // ACK withheld on the TEST write -> timeout after 16 REQ cycles
    set_in(2'b10, 1'b0, 2'b10, 1'b1, 16'h7FFF, 16'h0000);
    exp_q.push_back('{1'b1, 9'h000, 16'h0840});
    blk_en = 1'b1; blk_addr = 9'h009;
    START = 1'b1; tick(); START = 1'b0;
    n = 0;
    while (!ERR && n < 60) begin tick(); n++; end
    check("t3_err_state", 32'({ERR, BUSY, CFG_DONE, REG_REQ}), 32'h8);
    tick();
    check("t3_req_len", 32'(last_run), 32'd16);
    snap = req_starts;
    repeat (30) tick();
    check("t3_no_req", 32'(req_starts - snap), 32'h0);
    check("t3_err_sticky", 32'(ERR), 32'h1);
    blk_en = 1'b0;
    REG_RDATA = 16'h0004;
    set_in(2'b00, 1'b1, 2'b00, 1'b0, 16'hAAAA, 16'h5555);
    push_cfg(16'h0100, 16'h0000, 16'hAAAA, 16'h5555);
    START = 1'b1; tick(); START = 1'b0;
    check("t3_err_clr", 32'({ERR, BUSY}), 32'h1);
    wait_done(40, n);
    check("t3_relaunch", 32'(n), 32'd9);
    wait_valid(30, n);
    check("t3_poll_resume", 32'({LINK_UP, STATUS}), 32'h10004);

    // Reset while the SKEW1 request is outstanding
    blk_en = 1'b1; blk_addr = 9'h104;
    push_cfg(16'h0100, 16'h0000, 16'hAAAA, 16'h5555);
    START = 1'b1; tick(); START = 1'b0;
    n = 0;
    while (!(REG_REQ && REG_ADDR == 9'h104) && n < 20) begin tick(); n++; end
    check("t6_in_skew1", 32'({REG_REQ, REG_ADDR}), 32'h304);
    RST = 1'b1; tick();
    check_zero("t6_rst");
    check("t6_sb_left", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    blk_en = 1'b0;
    set_in(2'b01, 1'b1, 2'b10, 1'b0, 16'h0C0C, 16'h3030);
    push_cfg(16'h2100, 16'h4000, 16'h0C0C, 16'h3030);
    RST = 1'b0;
    repeat (9) tick();
    check("t6_pre_done", 32'({CFG_DONE, BUSY}), 32'h1);
    tick();
    check("t6_done", 32'({CFG_DONE, BUSY}), 32'h2);

    // AUTO_START=0 / POLL_EN=0 instance: runs only on START, idles afterwards
    check("opt_noauto_after_rst", 32'(req2_starts), 32'h0);
    START2 = 1'b1; tick(); START2 = 1'b0;
    repeat (8) tick();
    check("opt2_pre_done", 32'({CFG_DONE2, BUSY2}), 32'h1);
    tick();
    check("opt2_done", 32'({CFG_DONE2, BUSY2}), 32'h2);
    repeat (30) tick();
    check("opt2_reqs", 32'(req2_starts), 32'd4);
    check("opt2_no_poll", 32'(sv2_cnt), 32'h0);
    check("opt2_done_hold", 32'({CFG_DONE2, BUSY2, REG_REQ2}), 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
